// File: rtl/reg_snapshot_dumper_pkg.sv
// Shared types and width helper for the register snapshot dumper.
package reg_snapshot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_READ,
      ST_SEND,
      ST_DONE
   } snap_state_e;

   // Width able to index n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/reg_snapshot_dumper_if.sv
// Register-file read port plus valid/ready snapshot stream, seen from the dumper (master) and the sink/regfile side (slave).
interface reg_snapshot_dumper_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4,
   parameter int SNAP_W = 2
);
   logic [IDX_W-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;
   logic [SNAP_W-1:0] out_snap;
   logic              out_last;

   modport master (
      output rd_addr,
      input  rd_data,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_idx,
      output out_snap,
      output out_last
   );

   modport slave (
      input  rd_addr,
      output rd_data,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_idx,
      input  out_snap,
      input  out_last
   );
endinterface

// File: rtl/reg_snapshot_dumper_snap_interval_timer.sv
// Down-counter that times the idle gap before each snapshot's first read; expires at terminal count zero.
module snap_interval_timer
   import reg_snapshot_pkg::*;
#(
   parameter int SNAP_INTERVAL = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expired
);
   localparam int CNT_W = clog2_min1(SNAP_INTERVAL);
   // Loaded with N-1 so that the expire cycle itself is the Nth waiting cycle.
   localparam logic [CNT_W-1:0] LOAD_VAL = (SNAP_INTERVAL > 0) ? CNT_W'(SNAP_INTERVAL - 1) : '0;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/reg_snapshot_dumper.sv
// Register-file snapshot engine: reads NUM_REGS registers NUM_SNAPS times and streams them over valid/ready.
// REG_SNAPSHOT_FREEZE_EN adds cpu_stall, held high across each snapshot's scan so it is coherent.
module reg_snapshot_dumper
   import reg_snapshot_pkg::*;
#(
   parameter int DATA_W        = 16,
   parameter int NUM_REGS      = 16,
   parameter int NUM_SNAPS     = 3,
   parameter int SNAP_INTERVAL = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   reg_snapshot_dumper_if.master bus,
   output logic                  busy,
   output logic                  done
`ifdef REG_SNAPSHOT_FREEZE_EN
   ,
   output logic                  cpu_stall
`endif
);
   // state | meaning
   // IDLE  | after reset, waiting for start
   // WAIT  | interval timer running before a snapshot
   // READ  | one cycle: capture rd_data for idx into the output word
   // SEND  | word presented, waiting for out_ready
   // DONE  | all snapshots streamed, waiting for start

   localparam int IDX_W  = clog2_min1(NUM_REGS);
   localparam int SNAP_W = clog2_min1(NUM_SNAPS);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REGS - 1);
   localparam logic [SNAP_W-1:0] LAST_SNAP = SNAP_W'(NUM_SNAPS - 1);
   localparam snap_state_e       GAP_STATE = (SNAP_INTERVAL > 0) ? ST_WAIT : ST_READ;

   snap_state_e       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SNAP_W-1:0] snap_q, snap_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]  out_idx_q, out_idx_d;
   logic [SNAP_W-1:0] out_snap_q, out_snap_d;
   logic              out_last_q, out_last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timer_load;
   logic              timer_expired;
   logic              hs;

   snap_interval_timer #(.SNAP_INTERVAL(SNAP_INTERVAL)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .expired (timer_expired)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_snap_d  = out_snap_q;
      out_last_d  = out_last_q;
      timer_load  = 1'b0;
      hs          = out_valid_q && bus.out_ready;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               idx_d      = '0;
               snap_d     = '0;
               state_d    = GAP_STATE;
               timer_load = (SNAP_INTERVAL > 0);
            end
         end
         ST_WAIT: begin
            if (timer_expired) state_d = ST_READ;
         end
         ST_READ: begin
            out_valid_d = 1'b1;
            out_data_d  = bus.rd_data;
            out_idx_d   = idx_q;
            out_snap_d  = snap_q;
            out_last_d  = (idx_q == LAST_IDX);
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            if (hs) begin
               out_valid_d = 1'b0;
               if (idx_q != LAST_IDX) begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_READ;
               end else if (snap_q != LAST_SNAP) begin
                  idx_d      = '0;
                  snap_d     = snap_q + SNAP_W'(1);
                  state_d    = GAP_STATE;
                  timer_load = (SNAP_INTERVAL > 0);
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_WAIT) || (state_d == ST_READ) || (state_d == ST_SEND);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         snap_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_snap_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_snap_q  <= out_snap_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef REG_SNAPSHOT_FREEZE_EN
   logic cpu_stall_q, cpu_stall_d;

   // Raised on entry to the idx-0 read, dropped after the out_last handshake.
   always_comb begin
      cpu_stall_d = cpu_stall_q;
      if (state_q == ST_SEND && hs && out_last_q) cpu_stall_d = 1'b0;
      if (state_d == ST_READ && idx_d == '0) cpu_stall_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_stall_q <= 1'b0;
      end else begin
         cpu_stall_q <= cpu_stall_d;
      end
   end

   assign cpu_stall = cpu_stall_q;
`endif

   assign bus.rd_addr   = idx_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_snap  = out_snap_q;
   assign bus.out_last  = out_last_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: doc/reg_snapshot_dumper.md
Name: reg_snapshot_dumper

Overview:
Hardware register-file snapshot engine for the CPU: on a start pulse it reads every register of the register file in sequence and streams the values out over a valid/ready interface. It repeats this for a configurable number of snapshots, separated by a programmable cycle interval. This is the parametrised, synthesisable successor to the bench-side register dump loop, so boards and long regressions can observe architectural state without hierarchical peeking. It sits beside the register file on a dedicated read port.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 16, number of registers scanned (index 0..NUM_REGS-1)
NUM_SNAPS, 3, snapshots taken per start
SNAP_INTERVAL, 5, idle cycles between the end of one snapshot and the first read of the next; 0 allowed

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
rd_addr  out  IDX_W  register-file read address (IDX_W = max(1,clog2(NUM_REGS)))
rd_data  in  DATA_W  combinational read data for rd_addr
out_valid  out  1  stream word valid
out_ready  in  1  sink ready
out_data  out  DATA_W  captured register value
out_idx  out  IDX_W  register index of out_data
out_snap  out  SNAP_W  snapshot number (SNAP_W = max(1,clog2(NUM_SNAPS)))
out_last  out  1  high with the final word of each snapshot
busy  out  1  high in WAIT/READ/SEND
done  out  1  high in DONE

Behaviour:
- Reset (rst=0, any time, including mid-snapshot): state IDLE; idx, snap and interval counter 0; out_valid, out_last, busy, done 0; out_data, out_idx, out_snap 0; rd_addr 0. Any in-flight word is dropped; no partial snapshot resumes.
- States: IDLE, WAIT, READ, SEND, DONE.
- IDLE/DONE + start: idx=0, snap=0, done cleared; go to WAIT if SNAP_INTERVAL>0, else READ.
- start while busy: ignored.
- WAIT: the counter counts SNAP_INTERVAL cycles, then the FSM goes to READ. The first snapshot also waits.
- READ (one cycle): rd_addr=idx. rd_data is registered into out_data with out_idx=idx, out_snap=snap, out_last=(idx==NUM_REGS-1). out_valid is set and the FSM goes to SEND.
- rd_addr holds idx in all states; it holds the last value in IDLE/DONE.
- SEND: out_valid=1. out_data, out_idx, out_snap and out_last stay stable until out_valid&&out_ready.
- On handshake, out_valid drops next cycle, then:
  - idx<NUM_REGS-1: idx++ and go to READ.
  - idx==NUM_REGS-1 and snap<NUM_SNAPS-1: idx=0, snap++, go to WAIT (or READ if interval 0).
  - otherwise: go to DONE.
- Throughput: at most one word per 2 cycles. Latency from start to first out_valid is SNAP_INTERVAL+2 cycles.
- A snapshot always totals NUM_REGS words with indices 0..NUM_REGS-1 in order. A run totals NUM_SNAPS*NUM_REGS words.
- DONE: done=1 and busy=0 until the next start or reset.
- NUM_REGS=1: every word has out_last=1. NUM_SNAPS=1: no inter-snapshot WAIT.

Optional Feature:
Macro REG_SNAPSHOT_FREEZE_EN.
- Defined: adds output port cpu_stall (1 bit). cpu_stall is high from entry to READ at idx 0 through the out_last handshake of each snapshot, so every snapshot is a coherent freeze of the CPU. It is low in IDLE/WAIT/DONE and 0 at reset.
- Not defined: no cpu_stall port. The CPU runs freely, and a snapshot may mix values from different cycles.

Decomposition:
- Package reg_snapshot_pkg: state enum (IDLE, WAIT, READ, SEND, DONE) and a clog2-with-minimum-1 width helper function.
- Sub-module snap_interval_timer: load/count-down/expire timer parametrised by SNAP_INTERVAL, instantiated once.
- FSM and datapath stay in reg_snapshot_dumper.

Test Plan:
1. Defaults; regs preloaded with reg[i]=16'h0A00+i; out_ready=1; start pulse.
   -> First out_valid 7 cycles after start, with idx 0, data 16'h0A00.
   -> 48 words total; out_last at idx 15; snap 0,1,2; done after final handshake.
2. out_ready low for 4 cycles while out_valid at idx 5.
   -> out_data, out_idx and out_snap unchanged throughout; exactly one word for idx 5.
3. Write reg[3]=16'hBEEF from the testbench between snapshot 0 and 1.
   -> Snap 0 reports 16'h0A03 at idx 3; snaps 1 and 2 report 16'hBEEF.
4. rst=0 mid-SEND at snap 1, idx 9.
   -> All outputs are 0 in the same cycle.
   -> After release and start, the stream restarts at snap 0, idx 0.
5. SNAP_INTERVAL=0, NUM_REGS=1, NUM_SNAPS=1.
   -> One word, out_last=1, first out_valid 2 cycles after start.
   -> A start while busy is ignored.
6. With REG_SNAPSHOT_FREEZE_EN defined:
   -> cpu_stall is high exactly from READ idx 0 to the out_last handshake.
   -> cpu_stall is 0 during WAIT and DONE.
